cla3_digit_serial_adder: RTL

- Digit-serial controller that performs a WIDTH-bit addition by time-multiplexing one external 3-bit carry-lookahead slice.
- Sits directly upstream/downstream of that slice:
  - drives its a/b/cin inputs one 3-bit chunk per clock, LSB chunk first;
  - consumes its s/cout and registers the ripple carry between chunks.
- Exposes valid/ready handshakes on the operand side and the result side.

---
 rtl/cla3_digit_serial_adder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cla3_digit_serial_adder.sv
// cla3_digit_serial_adder
//   Adds two WIDTH-bit operands by time-multiplexing one external 3-bit
//   carry-lookahead slice. It sends one chunk per clock, LSB chunk first, and
//   registers the ripple carry between chunks.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_a, in_b, in_cin)
//   cla_a/cla_b/cla_cin chunk driven to the slice (0 outside RUN)
//   cla_s/cla_cout      slice result, combinational from cla_*
//   out_valid/out_ready result handshake (out_sum, out_cout)
//   busy                high while chunks are being processed
// Optional: define CLA3_DIGIT_SERIAL_OVF_EN to add out_ovf. This output is
//   the signed two's-complement overflow of the held result.
module cla3_digit_serial_adder #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [2:0]       cla_a,
  output logic [2:0]       cla_b,
  output logic             cla_cin,
  input  logic [2:0]       cla_s,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / 3;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  // Reject widths that do not split into whole 3-bit chunks
  if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
    $error("cla3_digit_serial_adder: WIDTH must be a multiple of 3 and >= 3");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             busy_q, busy_d;
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
  logic             out_ovf_q, out_ovf_d;
`endif

  // Operand side can take a new pair when idle or while the result is being drained
  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  end

  // Chunk selection toward the slice
  always_comb begin
    cla_a   = 3'b000;
    cla_b   = 3'b000;
    cla_cin = 1'b0;
    if (state_q == RUN) begin
      cla_cin = carry_q;
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx_q == IW'(i)) begin
          cla_a = a_q[3*i +: 3];
          cla_b = b_q[3*i +: 3];
        end
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
    out_ovf_d   = out_ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
        // When out_ready and in_valid coincide in DONE, the new pair is taken on the same edge
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[3*i +: 3] = cla_s;
          end
        end
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // The result is snapshotted on entry to DONE, so it stays put through the next RUN
    if ((state_q == RUN) && (state_d == DONE)) begin
      out_sum_d  = sum_d;
      out_cout_d = cla_cout;
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
      // Carry into the MSB is recovered from the MSB sum bit and the MSB operand bits
      out_ovf_d  = sum_d[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cla_cout;
`endif
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  // State and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      busy_q      <= busy_d;
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign busy      = busy_q;
`ifdef CLA3_DIGIT_SERIAL_OVF_EN
  assign out_ovf   = out_ovf_q;
`endif

endmodule
